ps2_kbd: RTL

//  PS/2 keyboard receiver presented as a 2-register CPU-bus peripheral.

---
 rtl/ps2_kbd.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/ps2_kbd.sv
// ps2_kbd -- PS/2 keyboard receiver exposed as a two-register CPU-bus peripheral.
//
// This block deserialises PS/2 frames and queues the received scan codes in a
// small FIFO. It drives a level interrupt into the 6502 IRQ OR-tree. Its dout
// is registered and feeds the CPU data-input mux.
//
// Parameters
//   FIFO_AW      FIFO address width; depth = 2**FIFO_AW bytes
//   TIMEOUT_CYC  clk cycles without a PS/2 clock fall mid-frame before abort
//
// Ports
//   clk       system clock
//   reset     synchronous, active-high reset
//   cs        chip select
//   we        CPU write enable
//   rs        register select: 0 = STATUS/CONTROL, 1 = DATA
//   din       CPU write data
//   dout      registered read data (1-cycle latency, holds when not read)
//   irq       level interrupt request, active-high
//   ps2_clk   PS/2 clock pin (asynchronous)
//   ps2_dat   PS/2 data pin (asynchronous)
//
// Register map
//   rs=0 rd  STATUS = {irq_en, 3'b0, full, err, ovr, nonempty}
//   rs=0 wr  irq_en <= din[7]; din[0]=1 flushes the FIFO and clears ovr/err
//   rs=1 rd  DATA   = FIFO head, popped on the same edge (8'h00 when empty)
//   rs=1 wr  ignored
//
// Build option
//   PS2_PARITY_EN  when defined, frames with bad odd parity set err and are
//                  dropped; otherwise the parity bit is shifted in but ignored.

module ps2_kbd #(
  parameter int FIFO_AW     = 3,
  parameter int TIMEOUT_CYC = 32000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs,
  input  logic       we,
  input  logic       rs,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       irq,
  input  logic       ps2_clk,
  input  logic       ps2_dat
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int TW    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT_CYC - 1);

`ifdef PS2_PARITY_EN
  localparam logic PARITY_CHECK = 1'b1;
`else
  localparam logic PARITY_CHECK = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_CHECK
  } rx_state_t;

  // ---------------------------------------------------------------------------
  // Input synchronisers and fall detection
  // ---------------------------------------------------------------------------
  logic [1:0] clk_sync;
  logic [1:0] dat_sync;
  logic       clk_prev;
  logic       fall;
  logic       dat_bit;

  // The synchronisers reset to the idle-high line level so that leaving reset
  // never looks like a clock fall.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its inputs, whatever the statement order.
    if (reset) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_dat};
      clk_prev <= clk_sync[1];
    end
  end

  assign fall    = clk_prev & ~clk_sync[1];
  assign dat_bit = dat_sync[1];

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  rx_state_t       state, state_next;
  logic [9:0]      shreg;      // {stop, parity, D7..D0} once the frame is complete
  logic [3:0]      bitcnt;
  logic [TW-1:0]   tcnt;
  logic            push_req;
  logic            set_err;
  logic            frame_bad;

  // The stop bit must be 1. Parity is checked only in the parity-enabled build.
  assign frame_bad = ~shreg[9] | (PARITY_CHECK & ~(^shreg[8:0]));

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_next = state;
    push_req   = 1'b0;
    set_err    = 1'b0;
    case (state)
      S_IDLE: begin
        if (fall && !dat_bit) state_next = S_SHIFT;
      end
      S_SHIFT: begin
        if (fall) begin
          if (bitcnt == 4'd9) state_next = S_CHECK;
        end else if (tcnt == TCNT_LAST) begin
          state_next = S_IDLE;
          set_err    = 1'b1;
        end
      end
      S_CHECK: begin
        if (frame_bad) set_err  = 1'b1;
        else           push_req = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg  <= '0;
      bitcnt <= '0;
      tcnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          bitcnt <= '0;
          tcnt   <= '0;
        end
        S_SHIFT: begin
          if (fall) begin
            shreg  <= {dat_bit, shreg[9:1]};
            bitcnt <= bitcnt + 4'd1;
            tcnt   <= '0;
          end else begin
            tcnt   <= tcnt + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic rd_stat;
  logic rd_data;
  logic wr_ctrl;
  logic flush;
  logic unused_din;

  assign rd_stat    = cs & ~we & ~rs;
  assign rd_data    = cs & ~we & rs;
  assign wr_ctrl    = cs & we & ~rs;
  assign flush      = wr_ctrl & din[0];
  assign unused_din = ^din[6:1];

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]       mem [DEPTH];
  logic [FIFO_AW:0] wptr, rptr;
  logic             empty, full;
  logic             pop, do_push, set_ovr;
  logic             irq_en, err, ovr;

  assign empty = (wptr == rptr);
  assign full  = (wptr[FIFO_AW] != rptr[FIFO_AW]) &&
                 (wptr[FIFO_AW-1:0] == rptr[FIFO_AW-1:0]);

  // A pop frees the slot on the same edge, so a full FIFO can still take a
  // push when it is being read. A flush discards any same-cycle push.
  assign pop     = rd_data & ~empty;
  assign do_push = push_req & ~flush & (~full | pop);
  assign set_ovr = push_req & ~flush & full & ~pop;

  // NOTE: the storage array has no reset. Emptiness is defined by the pointers
  // alone, so resetting the pointers is enough, and the array can map to RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[FIFO_AW-1:0]] <= shreg[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr   <= '0;
      rptr   <= '0;
      irq_en <= 1'b0;
      err    <= 1'b0;
      ovr    <= 1'b0;
      dout   <= 8'h00;
      irq    <= 1'b0;
    end else begin
      if (flush) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (do_push) wptr <= wptr + 1'b1;
        if (pop)     rptr <= rptr + 1'b1;
      end

      if (wr_ctrl) irq_en <= din[7];

      if (flush)        err <= 1'b0;
      else if (set_err) err <= 1'b1;

      if (flush)        ovr <= 1'b0;
      else if (set_ovr) ovr <= 1'b1;

      if (rd_stat)
        dout <= {irq_en, 3'b000, full, err, ovr, ~empty};
      else if (rd_data)
        dout <= empty ? 8'h00 : mem[rptr[FIFO_AW-1:0]];

      irq <= irq_en & ~empty;
    end
  end

endmodule
